// File: rtl/mem_access_responder_pkg.sv
// Shared types and helpers for the MEM-stage load/store responder.
package mem_access_responder_pkg;

   typedef enum logic [1:0] {
      MAS_IDLE  = 2'd0,
      MAS_ISSUE = 2'd1,
      MAS_WAIT  = 2'd2,
      MAS_DONE  = 2'd3
   } mas_state_e;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // True when the access size does not fit its address, or the size code is reserved.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = addr_lo[0];
         SIZE_WORD: bad = (addr_lo != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for stores and lane extract/extend for loads.
module mem_lane_align
   import mem_access_responder_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        load_unsigned,
   input  logic [31:0] store_data,
   input  logic [31:0] load_data,
   output logic        misaligned,
   output logic [3:0]  byte_en,
   output logic [31:0] lane_data,
   output logic [31:0] load_value
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   assign misaligned = is_misaligned(size, addr_lo);

   // Replicate store data across lanes and pick the byte enables for the addressed lanes.
   always_comb begin
      byte_en   = 4'b0000;
      lane_data = store_data;
      case (size)
         SIZE_BYTE: begin
            byte_en   = 4'b0001 << addr_lo;
            lane_data = {4{store_data[7:0]}};
         end
         SIZE_HALF: begin
            byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{store_data[15:0]}};
         end
         SIZE_WORD: begin
            byte_en   = 4'b1111;
            lane_data = store_data;
         end
         default: begin
            byte_en   = 4'b0000;
            lane_data = store_data;
         end
      endcase
   end

   // Select the addressed byte/half of the read word and extend it to 32 bits.
   always_comb begin
      byte_s = load_data[7:0];
      case (addr_lo)
         2'd0:    byte_s = load_data[7:0];
         2'd1:    byte_s = load_data[15:8];
         2'd2:    byte_s = load_data[23:16];
         2'd3:    byte_s = load_data[31:24];
         default: byte_s = load_data[7:0];
      endcase
      half_s = addr_lo[1] ? load_data[31:16] : load_data[15:0];
      case (size)
         SIZE_BYTE: load_value = load_unsigned ? {24'h000000, byte_s} : {{24{byte_s[7]}}, byte_s};
         SIZE_HALF: load_value = load_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
         SIZE_WORD: load_value = load_data;
         default:   load_value = 32'h00000000;
      endcase
   end

endmodule

// File: rtl/mem_access_responder.sv
// MEM-stage responder: accepts one load/store request, drives the data RAM,
// and returns a single-cycle completion pulse with extended load data.
module mem_access_responder
   import mem_access_responder_pkg::*;
#(
   parameter int ADDR_W   = 16,
   parameter int READ_LAT = 1
)
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              busy,
   output logic              resp_done,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   if (READ_LAT < 1 || READ_LAT > 7) begin : g_bad_read_lat
      $error("mem_access_responder: READ_LAT must be in 1..7");
   end

   localparam logic [2:0] LAT_M1 = 3'(READ_LAT - 1);

   mas_state_e        state_r, state_nxt_s;
   logic [2:0]        cnt_r, cnt_nxt_s;
   logic              we_r, unsigned_r;
   logic [1:0]        size_r, addr_lo_r;
   logic              latch_s;
   logic              busy_nxt_s, done_nxt_s, err_nxt_s, mem_en_nxt_s;
   logic [31:0]       rdata_nxt_s, mem_wdata_nxt_s;
   logic [3:0]        mem_we_nxt_s;
   logic [ADDR_W-3:0] mem_addr_nxt_s;

   logic [1:0]        al_size_s, al_addr_lo_s;
   logic              misaligned_s;
   logic [3:0]        byte_en_s;
   logic [31:0]       lane_data_s, load_value_s;

   // The aligner sees the live request while idle and the latched request afterwards.
   assign al_size_s    = (state_r == MAS_IDLE) ? req_size      : size_r;
   assign al_addr_lo_s = (state_r == MAS_IDLE) ? req_addr[1:0] : addr_lo_r;

   mem_lane_align u_align (
      .size          (al_size_s),
      .addr_lo       (al_addr_lo_s),
      .load_unsigned (unsigned_r),
      .store_data    (req_wdata),
      .load_data     (mem_rdata),
      .misaligned    (misaligned_s),
      .byte_en       (byte_en_s),
      .lane_data     (lane_data_s),
      .load_value    (load_value_s)
   );

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_nxt_s     = state_r;
      cnt_nxt_s       = cnt_r;
      latch_s         = 1'b0;
      busy_nxt_s      = busy;
      done_nxt_s      = 1'b0;
      rdata_nxt_s     = resp_rdata;
      err_nxt_s       = resp_err;
      mem_en_nxt_s    = 1'b0;
      mem_we_nxt_s    = 4'b0000;
      mem_addr_nxt_s  = mem_addr;
      mem_wdata_nxt_s = mem_wdata;
      case (state_r)
         MAS_IDLE: begin
            if (req) begin
               latch_s    = 1'b1;
               busy_nxt_s = 1'b1;
               if (misaligned_s) begin
                  state_nxt_s = MAS_DONE;
                  done_nxt_s  = 1'b1;
                  err_nxt_s   = 1'b1;
                  rdata_nxt_s = 32'h00000000;
               end else begin
                  state_nxt_s    = MAS_ISSUE;
                  mem_en_nxt_s   = 1'b1;
                  mem_addr_nxt_s = req_addr[ADDR_W-1:2];
                  if (req_we) begin
                     mem_we_nxt_s    = byte_en_s;
                     mem_wdata_nxt_s = lane_data_s;
                  end else begin
                     mem_we_nxt_s = 4'b0000;
                  end
               end
            end else begin
               busy_nxt_s = 1'b0;
            end
         end
         MAS_ISSUE: begin
            if (we_r) begin
               state_nxt_s = MAS_DONE;
               done_nxt_s  = 1'b1;
               err_nxt_s   = 1'b0;
            end else begin
               state_nxt_s = MAS_WAIT;
               cnt_nxt_s   = LAT_M1;
            end
         end
         MAS_WAIT: begin
            if (cnt_r == 3'd0) begin
               state_nxt_s = MAS_DONE;
               done_nxt_s  = 1'b1;
               err_nxt_s   = 1'b0;
               rdata_nxt_s = load_value_s;
            end else begin
               cnt_nxt_s = cnt_r - 3'd1;
            end
         end
         MAS_DONE: begin
            state_nxt_s = MAS_IDLE;
            busy_nxt_s  = 1'b0;
         end
         default: begin
            state_nxt_s = MAS_IDLE;
            busy_nxt_s  = 1'b0;
         end
      endcase
   end

   // State, counter and registered outputs with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r    <= MAS_IDLE;
         cnt_r      <= 3'd0;
         busy       <= 1'b0;
         resp_done  <= 1'b0;
         resp_rdata <= 32'h00000000;
         resp_err   <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 4'b0000;
         mem_addr   <= '0;
         mem_wdata  <= 32'h00000000;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         busy       <= busy_nxt_s;
         resp_done  <= done_nxt_s;
         resp_rdata <= rdata_nxt_s;
         resp_err   <= err_nxt_s;
         mem_en     <= mem_en_nxt_s;
         mem_we     <= mem_we_nxt_s;
         mem_addr   <= mem_addr_nxt_s;
         mem_wdata  <= mem_wdata_nxt_s;
      end
   end

   // Capture the request attributes needed after the accepting edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         we_r       <= 1'b0;
         unsigned_r <= 1'b0;
         size_r     <= 2'b00;
         addr_lo_r  <= 2'b00;
      end else if (latch_s) begin
         we_r       <= req_we;
         unsigned_r <= req_unsigned;
         size_r     <= req_size;
         addr_lo_r  <= req_addr[1:0];
      end else begin
         we_r       <= we_r;
         unsigned_r <= unsigned_r;
         size_r     <= size_r;
         addr_lo_r  <= addr_lo_r;
      end
   end

endmodule

// File: tb/tb_mem_access_responder.sv
// Directed bench: one responder with READ_LAT=1 and one with READ_LAT=3, each on a RAM model.
module tb_mem_access_responder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req, sel;
   logic        req_we, req_unsigned;
   logic [1:0]  req_size;
   logic [15:0] req_addr;
   logic [31:0] req_wdata;

   logic        busy1, done1, err1, en1, busy3, done3, err3, en3;
   logic [31:0] rdata1, wdata1, rdata3, wdata3, mrd1, mrd3;
   logic [3:0]  we1, we3;
   logic [13:0] addr1, addr3;

   logic [31:0] ram1 [0:16383];
   logic [31:0] ram3 [0:16383];
   logic [31:0] p3a, p3b;

   int n_checks = 0;
   int n_pass   = 0;

   int          r_done_cyc, r_done_cnt, r_en_cnt;
   logic [3:0]  r_we;
   logic [31:0] r_wd, r_rdata;
   logic        r_err;
   logic [15:0] r_busy;

   always #5 clk = ~clk;

   mem_access_responder #(.ADDR_W(16), .READ_LAT(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .req(req & ~sel), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .busy(busy1), .resp_done(done1), .resp_rdata(rdata1),
      .resp_err(err1), .mem_en(en1), .mem_we(we1), .mem_addr(addr1),
      .mem_wdata(wdata1), .mem_rdata(mrd1)
   );

   mem_access_responder #(.ADDR_W(16), .READ_LAT(3)) dut3 (
      .clk(clk), .reset_n(reset_n), .req(req & sel), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .busy(busy3), .resp_done(done3), .resp_rdata(rdata3),
      .resp_err(err3), .mem_en(en3), .mem_we(we3), .mem_addr(addr3),
      .mem_wdata(wdata3), .mem_rdata(mrd3)
   );

   // RAM model with one cycle of read latency.
   always @(posedge clk) begin
      if (en1) begin
         for (int i = 0; i < 4; i++) begin
            if (we1[i]) ram1[addr1][8*i +: 8] <= wdata1[8*i +: 8];
         end
         mrd1 <= ram1[addr1];
      end
   end

   // RAM model with three cycles of read latency.
   always @(posedge clk) begin
      if (en3) begin
         for (int j = 0; j < 4; j++) begin
            if (we3[j]) ram3[addr3][8*j +: 8] <= wdata3[8*j +: 8];
         end
         p3a <= ram3[addr3];
      end
      p3b  <= p3a;
      mrd3 <= p3b;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Issue one request, then watch 12 cycles; optional extra req pulse and reset pulse.
   task automatic run_req(input logic s, input logic we, input logic [1:0] sz, input logic un,
                          input logic [15:0] a, input logic [31:0] wd,
                          input int poke_cyc, input int rst_cyc);
      @(negedge clk);
      sel = s; req_we = we; req_size = sz; req_unsigned = un;
      req_addr = a; req_wdata = wd; req = 1'b1;
      @(posedge clk);
      r_done_cyc = -1; r_done_cnt = 0; r_en_cnt = 0;
      r_we = 4'b0000; r_wd = 32'h0; r_rdata = 32'h0; r_err = 1'b0; r_busy = 16'h0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         req     = (c == poke_cyc);
         reset_n = (c != rst_cyc);
         r_busy[c] = sel ? busy3 : busy1;
         if (sel ? en3 : en1) begin
            r_en_cnt++;
            r_we = sel ? we3 : we1;
            r_wd = sel ? wdata3 : wdata1;
         end
         if (sel ? done3 : done1) begin
            r_done_cnt++;
            if (r_done_cyc < 0) begin
               r_done_cyc = c;
               r_rdata = sel ? rdata3 : rdata1;
               r_err   = sel ? err3 : err1;
            end
         end
      end
   endtask

   initial begin
      reset_n = 1'b0; req = 1'b0; sel = 1'b0; req_we = 1'b0; req_size = 2'd0;
      req_unsigned = 1'b0; req_addr = 16'h0; req_wdata = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'h0, busy1}, 32'h0);
      chk("rst_done", {31'h0, done1 | done3}, 32'h0);
      chk("rst_rdata", rdata1, 32'h0);
      chk("rst_err", {31'h0, err1}, 32'h0);
      chk("rst_mem_en", {31'h0, en1 | en3}, 32'h0);
      chk("rst_mem_we", {28'h0, we1}, 32'h0);
      chk("rst_mem_addr", {18'h0, addr1}, 32'h0);
      chk("rst_mem_wdata", wdata1, 32'h0);
      reset_n = 1'b1;

      // Word store then word load at 0x0010.
      run_req(1'b0, 1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, 0, 0);
      chk("sw_done_cyc", 32'(r_done_cyc), 32'd2);
      chk("sw_busy_c1", {31'h0, r_busy[1]}, 32'h1);
      chk("sw_en_cnt", 32'(r_en_cnt), 32'd1);
      chk("sw_we", {28'h0, r_we}, 32'hF);
      chk("sw_wdata", r_wd, 32'hDEADBEEF);
      chk("sw_err", {31'h0, r_err}, 32'h0);
      chk("sw_rdata_held", r_rdata, 32'h0);
      chk("sw_addr", {18'h0, addr1}, 32'h4);
      run_req(1'b0, 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 0, 0);
      chk("lw_done_cyc", 32'(r_done_cyc), 32'd3);
      chk("lw_rdata", r_rdata, 32'hDEADBEEF);
      chk("lw_we", {28'h0, r_we}, 32'h0);
      chk("lw_err", {31'h0, r_err}, 32'h0);

      // Byte loads from word 0x00000080 at 0x0020.
      run_req(1'b0, 1'b1, 2'd2, 1'b0, 16'h0020, 32'h00000080, 0, 0);
      run_req(1'b0, 1'b0, 2'd0, 1'b0, 16'h0020, 32'h0, 0, 0);
      chk("lb_signed", r_rdata, 32'hFFFFFF80);
      run_req(1'b0, 1'b0, 2'd0, 1'b1, 16'h0020, 32'h0, 0, 0);
      chk("lbu", r_rdata, 32'h00000080);
      run_req(1'b0, 1'b0, 2'd0, 1'b0, 16'h0021, 32'h0, 0, 0);
      chk("lb_lane1", r_rdata, 32'h00000000);

      // Half store and signed half load at 0x0032.
      run_req(1'b0, 1'b1, 2'd1, 1'b0, 16'h0032, 32'h0000ABCD, 0, 0);
      chk("sh_we", {28'h0, r_we}, 32'hC);
      chk("sh_wdata", r_wd, 32'hABCDABCD);
      chk("sh_done_cyc", 32'(r_done_cyc), 32'd2);
      run_req(1'b0, 1'b0, 2'd1, 1'b0, 16'h0032, 32'h0, 0, 0);
      chk("lh_signed", r_rdata, 32'hFFFFABCD);

      // Misaligned and reserved-size requests.
      run_req(1'b0, 1'b0, 2'd1, 1'b0, 16'h0031, 32'h0, 0, 0);
      chk("mis_half_cyc", 32'(r_done_cyc), 32'd1);
      chk("mis_half_err", {31'h0, r_err}, 32'h1);
      chk("mis_half_rdata", r_rdata, 32'h0);
      chk("mis_half_en", 32'(r_en_cnt), 32'd0);
      run_req(1'b0, 1'b1, 2'd2, 1'b0, 16'h0042, 32'h11111111, 0, 0);
      chk("mis_word_cyc", 32'(r_done_cyc), 32'd1);
      chk("mis_word_err", {31'h0, r_err}, 32'h1);
      chk("mis_word_en", 32'(r_en_cnt), 32'd0);
      run_req(1'b0, 1'b0, 2'd3, 1'b0, 16'h0040, 32'h0, 0, 0);
      chk("rsv_size_cyc", 32'(r_done_cyc), 32'd1);
      chk("rsv_size_err", {31'h0, r_err}, 32'h1);
      chk("rsv_size_en", 32'(r_en_cnt), 32'd0);
      run_req(1'b0, 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, 0, 0);
      chk("after_mis_rdata", r_rdata, 32'hDEADBEEF);
      chk("after_mis_err", {31'h0, r_err}, 32'h0);

      // READ_LAT=3 instance: load with an ignored request while busy.
      run_req(1'b1, 1'b1, 2'd2, 1'b0, 16'h0050, 32'h87654321, 0, 0);
      chk("l3_sw_cyc", 32'(r_done_cyc), 32'd2);
      run_req(1'b1, 1'b0, 2'd2, 1'b0, 16'h0050, 32'h0, 2, 0);
      chk("l3_lw_cyc", 32'(r_done_cyc), 32'd5);
      chk("l3_lw_rdata", r_rdata, 32'h87654321);
      chk("l3_done_cnt", 32'(r_done_cnt), 32'd1);
      chk("l3_en_cnt", 32'(r_en_cnt), 32'd1);
      run_req(1'b1, 1'b0, 2'd1, 1'b1, 16'h0052, 32'h0, 0, 0);
      chk("l3_lhu", r_rdata, 32'h00008765);

      // Reset during WAIT drops the access; the next request completes normally.
      run_req(1'b1, 1'b0, 2'd2, 1'b0, 16'h0050, 32'h0, 0, 2);
      chk("rw_busy_c1", {31'h0, r_busy[1]}, 32'h1);
      chk("rw_busy_c3", {31'h0, r_busy[3]}, 32'h0);
      chk("rw_done_cnt", 32'(r_done_cnt), 32'd0);
      run_req(1'b1, 1'b0, 2'd2, 1'b0, 16'h0050, 32'h0, 0, 0);
      chk("rw_next_cyc", 32'(r_done_cyc), 32'd5);
      chk("rw_next_rdata", r_rdata, 32'h87654321);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_responder.md
Name: mem_access_responder

Overview:
- Responder side of the MEM-stage handshake in the multicycle core.
- The stage controller (initiator) pulses a load/store request; this block drives a synchronous word-wide data RAM and performs byte-lane steering, load extraction and sign extension.
- It returns a one-cycle completion pulse, so MEM_WAIT can end on completion rather than on a fixed count.
- It sits between the EX/MEM register outputs and the data RAM.

Parameters:
- ADDR_W, 16, byte-address width of req_addr; RAM word address is ADDR_W-2 bits.
- READ_LAT, 1, RAM read latency in cycles from mem_en to valid mem_rdata; legal range 1..7, elaboration error otherwise.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- req  in  1  one-cycle request strobe from stage controller
- req_we  in  1  1=store, 0=load
- req_size  in  2  0=byte, 1=half, 2=word, 3=reserved
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- busy  out  1  high from the cycle after an accepted req until the resp_done cycle inclusive
- resp_done  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; held until next resp_done
- resp_err  out  1  misaligned/reserved-size flag; valid with resp_done, held
- mem_en  out  1  RAM access strobe, one cycle per access
- mem_we  out  4  RAM byte write enables; bit i = bits [8i+7:8i]
- mem_addr  out  ADDR_W-2  RAM word address = req_addr[ADDR_W-1:2]
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  RAM read data, valid READ_LAT cycles after mem_en

Behaviour:
- Reset values: state IDLE, busy=0, resp_done=0, resp_rdata=0, resp_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, latency counter=0.
- Reset is synchronous and active-low on clk, and takes priority over everything. Asserted mid-operation, the block returns to IDLE next edge, drops the pending access and emits no resp_done.
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- Cycle 0 is the edge that samples req=1 in IDLE; request fields are latched at that edge.
- IDLE: if req is high, check alignment.
  - Misaligned means half with addr[0]=1, word with addr[1:0]!=0, or size=3.
  - Misaligned -> DONE. resp_done=1 and resp_err=1 in cycle 1, resp_rdata=0. No mem_en and no RAM write ever occur.
  - Aligned -> ISSUE.
- ISSUE (cycle 1): mem_en=1, mem_addr driven.
  - Store: mem_we lanes are byte -> 1<<addr[1:0]; half -> addr[1]?1100:0011; word -> 1111. mem_wdata is byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata. Next state is DONE; resp_done in cycle 2, resp_err=0, resp_rdata unchanged.
  - Load: mem_we=0000, next state WAIT, counter loaded with READ_LAT-1.
- WAIT: counter decrements each cycle. At the edge where mem_rdata is valid (cycle 1+READ_LAT), extract the lane and latch it into resp_rdata, then go to DONE.
  - resp_done is in cycle 2+READ_LAT; READ_LAT=1 gives done in cycle 3.
- Load extraction: byte = mem_rdata[8*addr[1:0]+:8]; half = mem_rdata[16*addr[1]+:16]; word = mem_rdata. Extension is by req_unsigned; word loads ignore req_unsigned.
- DONE: resp_done=1 for exactly one cycle, then IDLE. A new req is accepted in the cycle after resp_done, no earlier.
- req while busy is ignored with no queueing, no side effects and no error.
- mem_en and mem_we are 0 in every state except ISSUE. mem_addr and mem_wdata hold their last value outside ISSUE.
- Addresses wrap naturally within ADDR_W; there is no range check.

Decomposition:
- Shared define/package file holds:
  - FSM state encodings MAS_IDLE, MAS_ISSUE, MAS_WAIT, MAS_DONE;
  - size codes SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2.
- One natural sub-module: mem_lane_align (combinational), which does store lane steering, byte enables, the misalign check and load extract/extend.
- The FSM, counter and response registers remain in mem_access_responder.

Test Plan:
- Word store addr 0x0010 wdata 0xDEADBEEF, then word load 0x0010 (READ_LAT=1) -> mem_we=1111 in cycle 1, store done cycle 2; load resp_rdata=0xDEADBEEF, done cycle 3, err=0.
- RAM word 0x00000080 at 0x0020: signed byte load 0x0020 -> 0xFFFFFF80; unsigned -> 0x00000080; byte load 0x0021 -> 0x00000000.
- Half store 0xABCD at 0x0032 -> mem_we=1100, mem_wdata=0xABCDABCD; signed half load 0x0032 -> 0xFFFFABCD.
- Half load at 0x0031, word at 0x0042, size=3 at 0x0040 -> resp_done cycle 1, resp_err=1, resp_rdata=0, mem_en never high.
- READ_LAT=3: load issued -> mem_en cycle 1 only, resp_done cycle 5. A second req in cycle 2 is ignored, and exactly one resp_done occurs.
- reset_n low during WAIT -> next edge busy=0, resp_done never pulses, and the next req completes normally.
